packet_rx_buf: RTL and testbench

- Parametrised successor of the byte-wide packet receiver.
- Hunts for a configurable SFD, then checks the type, size and FCS of each packet.
- Payload goes into a circular store-and-forward buffer that holds several packets; only good packets are committed and replayed on an AXI-Stream-style byte output with tlast.
- Sits between the PHY-side rx interface and downstream consumers; adds multi-packet buffering, rollback on error, overflow drop, a selectable FCS mode and saturating statistics.

---
 rtl/packet_rx_buf.sv | 194 +++++++++++++++++++
 tb/tb_packet_rx_buf.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rx_buf.sv
// Byte-wide packet receiver with a circular store-and-forward payload buffer.
// Only frames that pass SFD, type, size and FCS checks are committed and replayed on a byte stream.
module packet_rx_buf #(
  parameter int unsigned G_MEM_SIZE    = 512,
  parameter logic [31:0] G_SFD         = 32'h5544557F,
  parameter logic [15:0] G_PACKET_TYPE = 16'h1234,
  parameter logic [7:0]  G_SIZE_MIN    = 8'h08,
  parameter logic [7:0]  G_SIZE_MAX    = 8'hFF,
  parameter int unsigned G_FCS_MODE    = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [7:0]                      rxd_in,
  input  logic                            rxdv_in,
  input  logic                            rxer_in,
  output logic [7:0]                      tdata_out,
  output logic                            tvalid_out,
  output logic                            tlast_out,
  input  logic                            tready_in,
  output logic [15:0]                     stat_packet_vld_cnt,
  output logic [15:0]                     stat_packet_err_cnt,
  output logic [15:0]                     stat_packet_ovf_cnt,
  output logic [$clog2(G_MEM_SIZE):0]     buf_level_out
);
  localparam int AW = $clog2(G_MEM_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] MEM_SIZE_P = PW'(G_MEM_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_SFD, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS, S_WAIT} state_t;

  function automatic logic [7:0] fcs_next(input logic [7:0] acc, input logic [7:0] b);
    if (G_FCS_MODE == 1) return acc + b;
    else                 return acc ^ b;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t state, state_nxt;
  logic [7:0] idx, size_p0, acc_p0, exp_byte;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, rd_ptr_nxt, free_space;
  logic [8:0] mem [G_MEM_SIZE];
  logic err_inc, ovf_inc, commit, rollback, wr_en, size_ld, idx_inc, idx_clr;
  logic last_byte, xfer, vld_p1, tlast_p1;
  logic [7:0] tdata_p1;

  assign buf_level_out = commit_ptr - rd_ptr;
  assign free_space    = MEM_SIZE_P - buf_level_out;
  assign last_byte     = (idx == size_p0 - 8'd1);

  always_comb begin
    exp_byte = 8'h00;
    if (state == S_SFD) begin
      case (idx)
        8'd0:    exp_byte = G_SFD[23:16];
        8'd1:    exp_byte = G_SFD[15:8];
        default: exp_byte = G_SFD[7:0];
      endcase
    end else begin
      exp_byte = (idx == 8'd0) ? G_PACKET_TYPE[15:8] : G_PACKET_TYPE[7:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    ovf_inc   = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    wr_en     = 1'b0;
    size_ld   = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxdv_in) begin
          idx_clr   = 1'b1;
          state_nxt = (rxd_in == G_SFD[31:24]) ? S_SFD : S_WAIT;
        end
      end
      // A broken preamble is just line noise: dropped without counting unless the PHY flagged it.
      S_SFD: begin
        if (!rxdv_in) state_nxt = S_IDLE;
        else if (rxer_in) begin
          err_inc = 1'b1;  state_nxt = S_WAIT;
        end else if (rxd_in != exp_byte) state_nxt = S_WAIT;
        else if (idx == 8'd2) begin
          idx_clr = 1'b1;  state_nxt = S_TYPE;
        end else idx_inc = 1'b1;
      end
      S_TYPE: begin
        if (!rxdv_in) begin
          err_inc = 1'b1;  state_nxt = S_IDLE;
        end else if (rxer_in || rxd_in != exp_byte) begin
          err_inc = 1'b1;  state_nxt = S_WAIT;
        end else if (idx == 8'd1) state_nxt = S_SIZE;
        else idx_inc = 1'b1;
      end
      S_SIZE: begin
        if (!rxdv_in) begin
          err_inc = 1'b1;  state_nxt = S_IDLE;
        end else if (rxer_in || rxd_in < G_SIZE_MIN || {1'b0, rxd_in} > {1'b0, G_SIZE_MAX}) begin
          err_inc = 1'b1;  state_nxt = S_WAIT;
        end else if (16'(free_space) < 16'(rxd_in)) begin
          ovf_inc = 1'b1;  state_nxt = S_WAIT;
        end else begin
          size_ld = 1'b1;  idx_clr = 1'b1;  state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!rxdv_in) begin
          err_inc = 1'b1;  rollback = 1'b1;  state_nxt = S_IDLE;
        end else if (rxer_in) begin
          err_inc = 1'b1;  rollback = 1'b1;  state_nxt = S_WAIT;
        end else begin
          wr_en   = 1'b1;
          idx_inc = 1'b1;
          if (last_byte) state_nxt = S_FCS;
        end
      end
      S_FCS: begin
        if (!rxdv_in) begin
          err_inc = 1'b1;  rollback = 1'b1;  state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT;
          if (!rxer_in && rxd_in == acc_p0) commit = 1'b1;
          else begin
            err_inc = 1'b1;  rollback = 1'b1;
          end
        end
      end
      S_WAIT:  if (!rxdv_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write side: speculative wr_ptr runs ahead, commit_ptr only moves on a good FCS.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx                 <= 8'd0;
      wr_ptr              <= '0;
      commit_ptr          <= '0;
      stat_packet_vld_cnt <= 16'd0;
      stat_packet_err_cnt <= 16'd0;
      stat_packet_ovf_cnt <= 16'd0;
    end else begin
      if (idx_clr)      idx <= 8'd0;
      else if (idx_inc) idx <= idx + 8'd1;
      if (rollback)     wr_ptr <= commit_ptr;
      else if (wr_en)   wr_ptr <= wr_ptr + PW'(1);
      if (commit)       commit_ptr <= wr_ptr;
      if (commit)       stat_packet_vld_cnt <= sat_inc(stat_packet_vld_cnt);
      if (err_inc)      stat_packet_err_cnt <= sat_inc(stat_packet_err_cnt);
      if (ovf_inc)      stat_packet_ovf_cnt <= sat_inc(stat_packet_ovf_cnt);
    end
  end

  always_ff @(posedge clk_in) begin
    if (size_ld) begin
      size_p0 <= rxd_in;
      acc_p0  <= 8'h00;
    end else if (wr_en) begin
      acc_p0  <= fcs_next(acc_p0, rxd_in);
    end
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {last_byte, rxd_in};
  end

  // Read side: output register always holds mem[rd_ptr]; addressing with the next pointer keeps 1 byte/cycle.
  assign xfer       = vld_p1 & tready_in;
  assign rd_ptr_nxt = rd_ptr + PW'(xfer);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr   <= '0;
      vld_p1   <= 1'b0;
      tdata_p1 <= 8'h00;
      tlast_p1 <= 1'b0;
    end else begin
      rd_ptr               <= rd_ptr_nxt;
      vld_p1               <= (rd_ptr_nxt != commit_ptr);
      {tlast_p1, tdata_p1} <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  assign tvalid_out = vld_p1;
  assign tdata_out  = tdata_p1;
  assign tlast_out  = tlast_p1;
endmodule

// File: tb/tb_packet_rx_buf.sv
// Directed bench: a 16-byte XOR-FCS receiver and a 512-byte sum-FCS receiver share one stimulus path.
`timescale 1ns/1ps
module tb_packet_rx_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, bp_en, rnd_ready, tready_set;
  logic [7:0]  rxd;
  logic        rxdv, rxer;
  logic        rxdv0, rxdv1, tready;
  logic [7:0]  tdata0, tdata1, tdata;
  logic        tvalid0, tvalid1, tvalid, tlast0, tlast1, tlast;
  logic [15:0] vld0, vld1, vld, err0, err1, err, ovf0, ovf1, ovf;
  logic [4:0]  level0;
  logic [9:0]  level1, level;

  assign tready = bp_en ? rnd_ready : tready_set;
  assign rxdv0  = rxdv & ~sel;
  assign rxdv1  = rxdv & sel;
  assign tdata  = sel ? tdata1  : tdata0;
  assign tvalid = sel ? tvalid1 : tvalid0;
  assign tlast  = sel ? tlast1  : tlast0;
  assign vld    = sel ? vld1    : vld0;
  assign err    = sel ? err1    : err0;
  assign ovf    = sel ? ovf1    : ovf0;
  assign level  = sel ? level1  : 10'(level0);

  packet_rx_buf #(.G_MEM_SIZE(16), .G_FCS_MODE(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd), .rxdv_in(rxdv0), .rxer_in(rxer),
    .tdata_out(tdata0), .tvalid_out(tvalid0), .tlast_out(tlast0), .tready_in(tready),
    .stat_packet_vld_cnt(vld0), .stat_packet_err_cnt(err0), .stat_packet_ovf_cnt(ovf0),
    .buf_level_out(level0));

  packet_rx_buf #(.G_MEM_SIZE(512), .G_FCS_MODE(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd), .rxdv_in(rxdv1), .rxer_in(rxer),
    .tdata_out(tdata1), .tvalid_out(tvalid1), .tlast_out(tlast1), .tready_in(tready),
    .stat_packet_vld_cnt(vld1), .stat_packet_err_cnt(err1), .stat_packet_ovf_cnt(ovf1),
    .buf_level_out(level1));

  int checks = 0;
  int errors = 0;
  logic [7:0] pl [256];
  logic [8:0] rq [$];
  int stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_beat = 9'd0;

  always @(posedge clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!tvalid || {tlast, tdata} !== prev_beat)) stall_viol++;
      if (tvalid && tready) rq.push_back({tlast, tdata});
      prev_stall = tvalid && !tready;
      prev_beat  = {tlast, tdata};
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // gap < 0 leaves rxdv asserted after the last byte sent.
  task automatic send_frame(input logic [31:0] sfd, input logic [15:0] typ, input logic [7:0] sz,
                            input int n, input logic [7:0] fcs, input int er_idx, input int cut_at,
                            input int gap);
    logic [7:0] st [$];
    st = {sfd[31:24], sfd[23:16], sfd[15:8], sfd[7:0], typ[15:8], typ[7:0], sz};
    for (int i = 0; i < n; i++) st.push_back(pl[i]);
    st.push_back(fcs);
    for (int i = 0; i < st.size(); i++) begin
      if (cut_at >= 0 && i >= cut_at) break;
      @(posedge clk); #1;
      rxd = st[i]; rxdv = 1'b1; rxer = (i == er_idx);
    end
    if (gap >= 0) begin
      @(posedge clk); #1;
      rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (rq.size() < n && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 1'b0; bp_en = 1'b0; tready_set = 1'b0;
    rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({tvalid0, tlast0, tdata0, vld0, err0, ovf0, level0} !== '0) begin
      errors++; $display("FAIL reset_dut0 got %h want 0", {tvalid0, tlast0, tdata0, vld0, err0, ovf0, level0});
    end
    checks++;
    if ({tvalid1, tlast1, tdata1, vld1, err1, ovf1, level1} !== '0) begin
      errors++; $display("FAIL reset_dut1 got %h want 0", {tvalid1, tlast1, tdata1, vld1, err1, ovf1, level1});
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Payload 01..08 XORs to 08.
  task automatic test_good_frame;
    int base;
    sel = 1'b0; tready_set = 1'b1; base = rq.size();
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    wait_beats(base + 8);
    checks++;
    if (rq.size() != base + 8) begin errors++; $display("FAIL good_beat_count got %0d want %0d", rq.size() - base, 8); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rq[base + i] !== {i == 7, 8'(i + 1)}) begin
        errors++; $display("FAIL good_beat%0d got %h want %h", i, rq[base + i], {i == 7, 8'(i + 1)});
      end
    end
    checks++;
    if ({vld, err, ovf} !== {16'd1, 16'd0, 16'd0}) begin errors++; $display("FAIL good_counts got %h want 000100000000", {vld, err, ovf}); end
    checks++;
    if (level !== 10'd0) begin errors++; $display("FAIL good_level got %0d want 0", level); end
  endtask

  // Bad FCS must leave nothing behind; the next frame (11..18, XOR 08) must come out alone.
  task automatic test_bad_fcs;
    int base;
    base = rq.size();
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h09, -1, -1, 2);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (rq.size() != base) begin errors++; $display("FAIL badfcs_beats got %0d want 0", rq.size() - base); end
    checks++;
    if ({vld, err} !== {16'd1, 16'd1}) begin errors++; $display("FAIL badfcs_counts got %h want 00010001", {vld, err}); end
    checks++;
    if (level !== 10'd0 || tvalid !== 1'b0) begin errors++; $display("FAIL badfcs_level got %0d/%b want 0/0", level, tvalid); end
    for (int i = 0; i < 8; i++) pl[i] = 8'h11 + 8'(i);
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    wait_beats(base + 8);
    checks++;
    if (rq.size() != base + 8) begin errors++; $display("FAIL rollback_beat_count got %0d want 8", rq.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rq[base + i] !== {i == 7, 8'h11 + 8'(i)}) begin
        errors++; $display("FAIL rollback_beat%0d got %h want %h", i, rq[base + i], {i == 7, 8'h11 + 8'(i)});
      end
    end
    checks++;
    if ({vld, err} !== {16'd2, 16'd1}) begin errors++; $display("FAIL rollback_counts got %h want 00020001", {vld, err}); end
  endtask

  task automatic test_faults;
    int base;
    do_reset;
    sel = 1'b0; tready_set = 1'b1; base = rq.size();
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_frame(32'h5544557F, 16'h1235, 8'h08, 8, 8'h08, -1, -1, 2);
    checks++;
    if (err !== 16'd1) begin errors++; $display("FAIL fault_type got %0d want 1", err); end
    send_frame(32'h5544557F, 16'h1234, 8'h07, 7, 8'h00, -1, -1, 2);
    checks++;
    if (err !== 16'd2) begin errors++; $display("FAIL fault_size got %0d want 2", err); end
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, 9, -1, 2);
    checks++;
    if (err !== 16'd3) begin errors++; $display("FAIL fault_rxer got %0d want 3", err); end
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, 12, 2);
    checks++;
    if (err !== 16'd4) begin errors++; $display("FAIL fault_trunc got %0d want 4", err); end
    send_frame(32'h5544557E, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    repeat (6) @(posedge clk); #1;
    checks++;
    if ({err, vld, ovf} !== {16'd4, 16'd0, 16'd0}) begin errors++; $display("FAIL fault_final got %h want 000400000000", {err, vld, ovf}); end
    checks++;
    if (rq.size() != base || level !== 10'd0) begin errors++; $display("FAIL fault_output got %0d/%0d want 0/0", rq.size() - base, level); end
  endtask

  // Payload 01..0C XORs to 0C; 12 of 16 bytes held leaves no room for 8 more.
  task automatic test_overflow;
    int base;
    do_reset;
    sel = 1'b0; tready_set = 1'b0; base = rq.size();
    for (int i = 0; i < 12; i++) pl[i] = 8'(i + 1);
    send_frame(32'h5544557F, 16'h1234, 8'h0C, 12, 8'h0C, -1, -1, 2);
    checks++;
    if (level !== 10'd12 || tvalid !== 1'b1) begin errors++; $display("FAIL ovf_first got %0d/%b want 12/1", level, tvalid); end
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    checks++;
    if ({ovf, vld, err} !== {16'd1, 16'd1, 16'd0}) begin errors++; $display("FAIL ovf_counts got %h want 000100010000", {ovf, vld, err}); end
    checks++;
    if (level !== 10'd12) begin errors++; $display("FAIL ovf_level got %0d want 12", level); end
    tready_set = 1'b1;
    wait_beats(base + 12);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (rq.size() != base + 12) begin errors++; $display("FAIL ovf_beat_count got %0d want 12", rq.size() - base); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (rq[base + i] !== {i == 11, 8'(i + 1)}) begin
        errors++; $display("FAIL ovf_beat%0d got %h want %h", i, rq[base + i], {i == 11, 8'(i + 1)});
      end
    end
    checks++;
    if (level !== 10'd0) begin errors++; $display("FAIL ovf_drain_level got %0d want 0", level); end
  endtask

  // Sum of FF FF 02..09 mod 256 is 2A.
  task automatic test_backpressure;
    int base;
    do_reset;
    sel = 1'b1; bp_en = 1'b1; base = rq.size();
    pl[0] = 8'hFF; pl[1] = 8'hFF;
    for (int i = 2; i < 10; i++) pl[i] = 8'(i);
    send_frame(32'h5544557F, 16'h1234, 8'h0A, 10, 8'h2A, -1, -1, 2);
    wait_beats(base + 10);
    bp_en = 1'b0; tready_set = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rq.size() != base + 10) begin errors++; $display("FAIL bp_beat_count got %0d want 10", rq.size() - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rq[base + i] !== {i == 9, pl[i]}) begin
        errors++; $display("FAIL bp_beat%0d got %h want %h", i, rq[base + i], {i == 9, pl[i]});
      end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d want 0", stall_viol); end
    checks++;
    if ({vld, err, level} !== {16'd1, 16'd0, 10'd0}) begin errors++; $display("FAIL bp_counts got %h want 00010000000", {vld, err, level}); end
    sel = 1'b0;
  endtask

  // Frame k carries k0..k9 (hex), whose XOR is always 01.
  task automatic test_wrap;
    int base;
    do_reset;
    sel = 1'b0; bp_en = 1'b0; tready_set = 1'b1; base = rq.size();
    for (int k = 1; k <= 6; k++) begin
      for (int i = 0; i < 10; i++) pl[i] = 8'(k * 16 + i);
      send_frame(32'h5544557F, 16'h1234, 8'h0A, 10, 8'h01, -1, -1, 4);
    end
    wait_beats(base + 60);
    checks++;
    if (rq.size() != base + 60) begin errors++; $display("FAIL wrap_beat_count got %0d want 60", rq.size() - base); end
    for (int k = 1; k <= 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (rq[base + (k - 1) * 10 + i] !== {i == 9, 8'(k * 16 + i)}) begin
          errors++; $display("FAIL wrap_beat%0d_%0d got %h want %h", k, i, rq[base + (k - 1) * 10 + i], {i == 9, 8'(k * 16 + i)});
        end
      end
    end
    checks++;
    if ({vld, err, ovf, level} !== {16'd6, 16'd0, 16'd0, 10'd0}) begin
      errors++; $display("FAIL wrap_counts got %h want %h", {vld, err, ovf, level}, {16'd6, 16'd0, 16'd0, 10'd0});
    end
  endtask

  task automatic test_reset_mid;
    int base;
    do_reset;
    sel = 1'b0; tready_set = 1'b0;
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    checks++;
    if (tvalid !== 1'b1 || level !== 10'd8) begin errors++; $display("FAIL rstmid_pre got %b/%0d want 1/8", tvalid, level); end
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, 11, -1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tvalid, tlast, tdata, vld, level} !== '0) begin errors++; $display("FAIL rstmid_async got %h want 0", {tvalid, tlast, tdata, vld, level}); end
    rxdv = 1'b0; rxer = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    tready_set = 1'b1; base = rq.size();
    for (int i = 0; i < 8; i++) pl[i] = 8'h31 + 8'(i);
    send_frame(32'h5544557F, 16'h1234, 8'h08, 8, 8'h08, -1, -1, 2);
    wait_beats(base + 8);
    checks++;
    if (rq.size() != base + 8) begin errors++; $display("FAIL rstmid_beat_count got %0d want 8", rq.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rq[base + i] !== {i == 7, 8'h31 + 8'(i)}) begin
        errors++; $display("FAIL rstmid_beat%0d got %h want %h", i, rq[base + i], {i == 7, 8'h31 + 8'(i)});
      end
    end
    checks++;
    if ({vld, err, level} !== {16'd1, 16'd0, 10'd0}) begin errors++; $display("FAIL rstmid_counts got %h want 00010000000", {vld, err, level}); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_fcs;
    test_faults;
    test_overflow;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
